// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: exe redirect inputs, instruction-memory request/response, decode handoff.
// master = fetch_unit side, slave = the environment (exe, imem, decode).
interface fetch_unit_if;
   logic        jmp_en;
   logic [31:0] jmp_addr;
   logic        clr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_ins;
   logic [31:0] id_ins_addr;

   modport master (
      input  jmp_en, jmp_addr, clr, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      output imem_req, imem_addr, id_valid, id_ins, id_ins_addr
   );

   modport slave (
      output jmp_en, jmp_addr, clr, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      input  imem_req, imem_addr, id_valid, id_ins, id_ins_addr
   );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch: owns the PC, buffers returned words, redirects/flushes on exe request.
// Grant at N -> rvalid N+1 -> id_valid N+2; requests stop once buffered + outstanding reaches DEPTH.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);
   localparam int            AW  = $clog2(DEPTH);
   localparam int            CW  = AW + 1;
   localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);

   logic [31:0]   pc, deliver_pc, resp_pc, redirect_pc;
   logic [CW-1:0] count, outstanding, drop;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   ins_mem  [DEPTH];
   logic [31:0]   addr_mem [DEPTH];
   logic [CW:0]   inflight;
   logic          flush, req, grant, rsp, push, pop, head_vld;

   assign flush       = bus.jmp_en || bus.clr;
   assign inflight    = {1'b0, count} + {1'b0, outstanding};
   assign req         = !rst && !flush && (inflight < CAP);
   assign grant       = req && bus.imem_gnt;
   // A response with nothing tracked is a leftover from before reset and is ignored.
   assign rsp         = bus.imem_rvalid && (outstanding != '0);
   assign push        = rsp && (drop == '0);
   assign head_vld    = (count != '0);
   assign pop         = head_vld && bus.id_ready;
   assign redirect_pc = bus.jmp_en ? {bus.jmp_addr[31:2], 2'b00} : deliver_pc;

   assign bus.imem_req    = req;
   assign bus.imem_addr   = pc;
   assign bus.id_valid    = head_vld;
   assign bus.id_ins      = ins_mem[rd_ptr];
   assign bus.id_ins_addr = addr_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         deliver_pc  <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ins_mem[i]  <= '0;
            addr_mem[i] <= '0;
         end
      end else if (flush) begin
         // Everything still in flight belongs to the old path; a same-cycle response is discarded too.
         pc          <= redirect_pc;
         deliver_pc  <= redirect_pc;
         resp_pc     <= redirect_pc;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= outstanding - CW'(rsp);
         drop        <= outstanding - CW'(rsp);
      end else begin
         if (grant) begin
            pc <= pc + 32'd4;
         end
         case ({grant, rsp})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: ;
         endcase
         if (rsp && (drop != '0)) begin
            drop <= drop - CW'(1);
         end
         if (push) begin
            ins_mem[wr_ptr]  <= bus.imem_rdata;
            addr_mem[wr_ptr] <= resp_pc;
            wr_ptr           <= wr_ptr + AW'(1);
            resp_pc          <= resp_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + AW'(1);
            deliver_pc <= addr_mem[rd_ptr] + 32'd4;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder, abstract next-address scoreboard,
// a table of redirect scenarios and hand-written timing sequences.
module tb_fetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] K     = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   typedef struct {
      bit          j;
      bit          c;
      logic [31:0] ja;
      int          pre;
      int          hold;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   rsp_t        mq[$];
   int          cyc = 0;
   int          lat_min = 1, lat_max = 1;
   int          total = 0, bad = 0;
   int          n_grants = 0;
   logic [31:0] exp_req, exp_del, prev_addr, last_del;
   bit          prev_req, prev_gnt, got_del;
   bit          o_req, o_valid, o_grant, o_hs;
   logic [31:0] o_addr, o_ins, o_ins_addr;

   task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_bit(input string nm, input bit act, input bit exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, sample outputs before the edge, update the reference model.
   task automatic step(input bit j, input bit c, input logic [31:0] ja, input bit rdy, input bit g);
      bit          fl;
      logic [31:0] tgt;
      bus.jmp_en   = j;
      bus.clr      = c;
      bus.jmp_addr = ja;
      bus.id_ready = rdy;
      bus.imem_gnt = g;
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mq[0].addr ^ K;
         mq.delete(0);
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = $urandom;
      end
      #1;
      o_req      = bus.imem_req;
      o_addr     = bus.imem_addr;
      o_valid    = bus.id_valid;
      o_ins      = bus.id_ins;
      o_ins_addr = bus.id_ins_addr;
      o_grant    = o_req && g;
      o_hs       = o_valid && rdy;
      fl         = j || c;
      got_del    = 1'b0;
      if (rst) begin
         mq.delete();
         exp_req  = 32'h0;
         exp_del  = 32'h0;
         prev_req = 1'b0;
      end else begin
         if (fl) begin
            chk_bit("req_in_flush", o_req, 1'b0);
         end else if (prev_req && !prev_gnt) begin
            chk_bit("req_hold", o_req, 1'b1);
            chk_eq("addr_hold", o_addr, prev_addr);
         end
         if (o_grant) begin
            chk_eq("req_addr", o_addr, exp_req);
            exp_req = exp_req + 32'd4;
            n_grants++;
            mq.push_back('{addr: o_addr, due: cyc + $urandom_range(lat_max, lat_min)});
            chk_bit("outstanding_cap", mq.size() <= DEPTH, 1'b1);
         end
         if (o_hs && !fl) begin
            chk_eq("del_addr", o_ins_addr, exp_del);
            chk_eq("del_ins", o_ins, exp_del ^ K);
            last_del = o_ins_addr;
            got_del  = 1'b1;
            exp_del  = exp_del + 32'd4;
         end
         if (fl) begin
            tgt     = j ? {ja[31:2], 2'b00} : exp_del;
            exp_req = tgt;
            exp_del = tgt;
         end
         prev_req  = o_req;
         prev_gnt  = g;
         prev_addr = o_addr;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         if (i >= 1) begin
            chk_bit("rst_req", o_req, 1'b0);
            chk_eq("rst_addr", o_addr, 32'h0);
            chk_bit("rst_valid", o_valid, 1'b0);
            chk_eq("rst_ins", o_ins, 32'h0);
            chk_eq("rst_ins_addr", o_ins_addr, 32'h0);
         end
      end
      rst = 1'b0;
   endtask

   task automatic run_until_del(output logic [31:0] a);
      bit found = 1'b0;
      a = 32'hDEAD_BEEF;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         if (got_del) begin
            a     = last_del;
            found = 1'b1;
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL del_timeout: got no delivery expected one within 40 cycles");
      end
   endtask

   initial begin
      vec_t        tbl[6];
      logic [31:0] a;
      int          nd;

      tbl[0] = '{j:1'b1, c:1'b0, ja:32'h0000_0103, pre:0, hold:0, e0:32'h100,       e1:32'h104,       e2:32'h108};
      tbl[1] = '{j:1'b0, c:1'b1, ja:32'h0000_0000, pre:2, hold:0, e0:32'h8,         e1:32'hC,         e2:32'h10};
      tbl[2] = '{j:1'b1, c:1'b1, ja:32'h0000_2000, pre:3, hold:0, e0:32'h2000,      e1:32'h2004,      e2:32'h2008};
      tbl[3] = '{j:1'b1, c:1'b0, ja:32'hFFFF_FFF8, pre:1, hold:3, e0:32'hFFFF_FFF8, e1:32'hFFFF_FFFC, e2:32'h0};
      tbl[4] = '{j:1'b1, c:1'b0, ja:32'h0000_0007, pre:2, hold:1, e0:32'h4,         e1:32'h8,         e2:32'hC};
      tbl[5] = '{j:1'b0, c:1'b1, ja:32'h0000_0000, pre:0, hold:2, e0:32'h0,         e1:32'h4,         e2:32'h8};

      rst = 1'b1;
      bus.jmp_en = 1'b0; bus.clr = 1'b0; bus.jmp_addr = '0; bus.id_ready = 1'b0;
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      @(negedge clk);

      // Reset start: first request, 2-cycle grant-to-valid latency, then full throughput.
      do_reset(3);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk_bit("first_req", o_req, 1'b1);
      chk_eq("first_addr", o_addr, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk_bit("valid_at_n1", o_valid, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk_bit("valid_at_n2", o_valid, 1'b1);
      chk_eq("first_ins_addr", o_ins_addr, 32'h0);
      chk_eq("first_ins", o_ins, K);
      repeat (6) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         chk_bit("throughput_del", o_hs, 1'b1);
         chk_bit("throughput_gnt", o_grant, 1'b1);
      end

      // Backpressure: issue cap, held head, ordered drain.
      do_reset(2);
      n_grants = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
         if (i >= 4) chk_bit("bp_req_low", o_req, 1'b0);
         if (i >= 2) chk_eq("bp_head", o_ins_addr, 32'h0);
      end
      chk_eq("bp_grants", n_grants, 32'd4);
      for (int k = 0; k < 4; k++) begin
         run_until_del(a);
         chk_eq("bp_order", a, 32'(k * 4));
      end

      // Jump with two responses in flight.
      do_reset(2);
      lat_min = 2; lat_max = 2;
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 32'h0000_0103, 1'b1, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk_bit("jmp_valid_next", o_valid, 1'b0);
      chk_bit("jmp_req_next", o_req, 1'b1);
      chk_eq("jmp_addr_next", o_addr, 32'h100);
      run_until_del(a);
      chk_eq("jmp_first_del", a, 32'h100);
      lat_min = 1; lat_max = 1;

      // Redirect table: flush after 'pre' deliveries, hold grant low 'hold' cycles, check next three.
      for (int r = 0; r < 6; r++) begin
         do_reset(2);
         for (int p = 0; p < tbl[r].pre; p++) run_until_del(a);
         step(tbl[r].j, tbl[r].c, tbl[r].ja, 1'b1, tbl[r].hold == 0);
         for (int h = 0; h < tbl[r].hold; h++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            chk_bit("tbl_req_stall", o_req, 1'b1);
            chk_eq("tbl_addr_stall", o_addr, tbl[r].e0);
         end
         run_until_del(a);
         chk_eq("tbl_del0", a, tbl[r].e0);
         run_until_del(a);
         chk_eq("tbl_del1", a, tbl[r].e1);
         run_until_del(a);
         chk_eq("tbl_del2", a, tbl[r].e2);
      end

      // Random traffic against the scoreboard.
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         int          rr;
         bit          j, c;
         logic [31:0] ja;
         rr = $urandom_range(0, 99);
         j  = (rr < 3) || (rr == 9);
         c  = (rr >= 3 && rr < 6) || (rr == 9);
         ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
         if (rr == 50 && $urandom_range(0, 9) == 0) begin
            do_reset(2);
         end else begin
            step(j, c, ja, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
         end
      end
      lat_min = 1; lat_max = 1;
      nd = 0;
      repeat (20) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         if (got_del) nd++;
      end
      chk_bit("drain_progress", nd > 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits upstream of decode and downstream of `exe`, closing the loop on `exe`'s redirect outputs. It owns the PC and issues in-order requests to instruction memory. Returned words are buffered in a small FIFO and handed to decode with a valid/ready handshake. It consumes `jmp_en`/`jmp_addr`/`clr` from `exe` to redirect, flush in-flight and buffered instructions, and restart fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, fetch-buffer entries; power of two, ≥2; also caps outstanding requests
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `jmp_en`  in  1  redirect from exe: flush, restart at `jmp_addr`
- `jmp_addr`  in  32  redirect target; bits [1:0] ignored (treated as 0)
- `clr`  in  1  flush from exe; without `jmp_en`, replay from the next undelivered address
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  word-aligned fetch address
- `imem_gnt`  in  1  request accepted this cycle (`imem_req && imem_gnt`)
- `imem_rvalid`  in  1  response valid; responses return in request order, ≥1 cycle after grant
- `imem_rdata`  in  32  instruction word
- `id_valid`  out  1  buffer head valid
- `id_ready`  in  1  decode accepts the head
- `id_ins`  out  32  head instruction
- `id_ins_addr`  out  32  head instruction address

## Operation
- **State:**
  - `pc`: next address to request.
  - `deliver_pc`: address of the next instruction to hand to decode.
  - FIFO with `count`.
  - `outstanding`: granted, not yet returned.
  - `drop`: responses still to discard after a flush.
- **Issue:** `imem_req = !rst && !flush && (count + outstanding < DEPTH)`. `imem_addr = pc`. On grant, `pc <= pc + 4` (32-bit wrap, 0xFFFF_FFFC → 0) and `outstanding++`.
- **Response:** on `imem_rvalid`, `outstanding--`.
  - If `drop > 0`: `drop--`, data discarded.
  - Else: push {`imem_rdata`, address} into the FIFO. The address comes from a tracked `resp_pc`, advanced by 4 per kept response.
  - The FIFO can never overflow because of the issue cap.
- **Deliver:** `id_valid = (count != 0)`. On `id_valid && id_ready`, pop and set `deliver_pc <= id_ins_addr + 4`.
- **Flush:** `flush = jmp_en || clr`. In the flush cycle:
  - FIFO emptied; `count <= 0`.
  - `drop <= outstanding + (grant this cycle? 0 : 0) - (rvalid this cycle ? 1 : 0)`. No grant can occur because `imem_req` is 0.
  - A response arriving in the flush cycle is discarded.
  - `pc <= jmp_en ? {jmp_addr[31:2],2'b00} : deliver_pc`, using `deliver_pc` before any update this cycle.
  - `resp_pc` and `deliver_pc` are loaded with the same value.
  - A decode handshake in the flush cycle is void: FIFO state is cleared and `deliver_pc` is not advanced by it.
- **Simultaneous:** `jmp_en` and `clr` together behave as `jmp_en`. Push and pop in the same cycle leaves `count` unchanged.
- **Restart:** the new fetch address may be issued on the cycle after the flush while `drop > 0`. Kept/dropped classification is strictly by response order.

## Timing
- **Reset values:**
  - `imem_req = 0`, `imem_addr = RESET_PC`.
  - `id_valid = 0`, `id_ins = 0`, `id_ins_addr = 0`.
  - `pc = deliver_pc = resp_pc = RESET_PC`.
  - All counters 0.
- **Reset mid-operation:** in-flight responses arriving after reset are not tracked. The memory must be quiesced by reset too.
- **First request:** the first cycle with `rst = 0`.
- **Latency:** grant at cycle N, `rvalid` at N+1 → `id_valid` at N+2. The FIFO output is registered; there is no bypass.
- **Throughput:** one instruction per cycle when memory grants every cycle and `id_ready = 1`.
- **After flush at cycle F:** `imem_req = 0` at F. The first new request is at F+1, and the earliest new `id_valid` is at F+3.
- **Stall:** with `id_ready = 0` and `count + outstanding = DEPTH`, `imem_req` drops to 0 and stays low until a pop.
- **Grant low:** when `imem_gnt = 0`, `imem_req` and `imem_addr` stay stable until granted, unless a flush occurs.

## Test plan
- **Reset start:** reset 3 cycles, then memory grants every cycle with 1-cycle `rvalid` returning `rdata = addr ^ 32'hA5A5_0000`, and `id_ready = 1`.
  - Required: requests at 0x0, 0x4, 0x8…
  - `id_valid` is first high 2 cycles after the first grant, with `id_ins_addr = 0x0` and `id_ins = 32'hA5A5_0000`.
- **Backpressure:** `id_ready = 0` for 10 cycles.
  - Required: exactly 4 grants; `imem_req` then stays 0.
  - `id_ins_addr` is held at 0x0; after release, 0x0, 0x4, 0x8, 0xC are delivered in order with no gaps or duplicates.
- **Jump with in-flight data:** with 2 outstanding requests, pulse `jmp_en = 1`, `jmp_addr = 32'h0000_0103`.
  - Required: `id_valid = 0` the next cycle.
  - Both stale responses are dropped; the next request is 0x100, and the first delivered `id_ins_addr` is 0x100.
- **Replay:** after 0x0 and 0x4 are delivered, pulse `clr` only.
  - Required: refetch starts at 0x8, and the next delivered address is 0x8.
- **Jump and clr together:** `jmp_en` and `clr` in the same cycle as an `id_valid && id_ready` handshake, `jmp_addr = 0x2000`.
  - Required: the handshaken instruction is not followed by any old-path address; the next delivered address is 0x2000.
- **Wrap and grant stall:** `jmp_addr = 32'hFFFF_FFF8`, then hold `imem_gnt = 0` for 3 cycles.
  - Required: `imem_addr` stays stable at 0xFFFF_FFF8 while ungranted.
  - Delivered addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
